// File: rtl/sdram_capture_writer_if.sv
// ---------------------------------------------------------------------------
// sdram_capture_writer_if
//   Avalon-MM write-side bus between the capture writer (master) and the
//   SDRAM controller's master multiplexer (slave).
//   Avalon_Address     : word address of the current write
//   Avalon_WriteData   : 16-bit write data (FIFO head)
//   Avalon_ByteEnable  : both bytes always enabled
//   Avalon_ChipEnable  : asserted while the writer is active
//   Avalon_Write       : write request
//   Avalon_WaitRequest : slave stall; the write completes when low
// ---------------------------------------------------------------------------
interface sdram_capture_writer_if #(
   parameter int unsigned ADDR_W = 25
);
   logic [ADDR_W-1:0] Avalon_Address;
   logic [15:0]       Avalon_WriteData;
   logic [1:0]        Avalon_ByteEnable;
   logic              Avalon_ChipEnable;
   logic              Avalon_Write;
   logic              Avalon_WaitRequest;

   modport master (
      output Avalon_Address,
      output Avalon_WriteData,
      output Avalon_ByteEnable,
      output Avalon_ChipEnable,
      output Avalon_Write,
      input  Avalon_WaitRequest
   );

   modport slave (
      input  Avalon_Address,
      input  Avalon_WriteData,
      input  Avalon_ByteEnable,
      input  Avalon_ChipEnable,
      input  Avalon_Write,
      output Avalon_WaitRequest
   );
endinterface

// File: rtl/sdram_capture_writer.sv
// ---------------------------------------------------------------------------
// sdram_capture_writer
//   Packs pairs of 8-bit ADC samples into 16-bit words (earlier sample in the
//   low byte), buffers them in a show-ahead FIFO and writes them as linear,
//   word-addressed single Avalon-MM writes into the SDRAM capture region.
//   Ports:
//     M100CLK, reset          : clock, asynchronous active-high reset
//     arm / stop              : start (IDLE/DONE) and stop (CAPTURE) pulses
//     wrap_en                 : circular capture when set, latched on arm
//     sample, sample_valid    : ADC sample stream
//     av                      : Avalon-MM write master
//     busy, done              : CAPTURE/DRAIN and DONE status
//     overflow                : sticky, a packed word was dropped on full FIFO
//     words_written           : completed Avalon writes since the last arm
// ---------------------------------------------------------------------------
module sdram_capture_writer #(
   parameter int unsigned       ADDR_W    = 25,
   parameter logic [ADDR_W-1:0] LAST_ADDR = 25'h1FF_FFFF,
   parameter int unsigned       FIFO_AW   = 4
) (
   input  logic                   M100CLK,
   input  logic                   reset,
   input  logic                   arm,
   input  logic                   stop,
   input  logic                   wrap_en,
   input  logic [7:0]             sample,
   input  logic                   sample_valid,
   sdram_capture_writer_if.master av,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow,
   output logic [ADDR_W-1:0]      words_written
);

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_e;

   localparam logic [FIFO_AW:0] DEPTH   = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ONE_W  = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] words_q, words_d;
   logic [ADDR_W-1:0] push_cnt_q, push_cnt_d;   // words formed, dropped ones included
   logic              overflow_q, overflow_d;
   logic              wrap_q, wrap_d;
   logic [7:0]        held_q, held_d;
   logic              held_vld_q, held_vld_d;
   logic [FIFO_AW:0]  wr_ptr_q, wr_ptr_d;       // extra MSB distinguishes full/empty
   logic [FIFO_AW:0]  rd_ptr_q, rd_ptr_d;
   logic [15:0]       fifo_mem [2**FIFO_AW];

   logic [FIFO_AW:0]  fifo_count;
   logic              active, av_write, pop, word_vld, push, quota_hit;

   assign fifo_count = wr_ptr_q - rd_ptr_q;
   assign active     = (state_q == S_CAPTURE) || (state_q == S_DRAIN);
   assign av_write   = active && (fifo_count != '0);
   assign pop        = av_write && !av.Avalon_WaitRequest;
   assign word_vld   = (state_q == S_CAPTURE) && sample_valid && held_vld_q;
   // Fullness is judged after a same-edge pop, so a draining FIFO never drops.
   assign push       = word_vld && ((fifo_count != DEPTH) || pop);
   assign quota_hit  = word_vld && !wrap_q && (push_cnt_q == LAST_ADDR);

   always_comb begin
      // NOTE: every next-state value defaults to its register first, so no
      // branch of this block can leave a signal unassigned and infer a latch.
      state_d    = state_q;
      addr_d     = addr_q;
      words_d    = words_q;
      push_cnt_d = push_cnt_q;
      overflow_d = overflow_q;
      wrap_d     = wrap_q;
      held_d     = held_q;
      held_vld_d = held_vld_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (arm) begin
               state_d    = S_CAPTURE;
               addr_d     = '0;
               words_d    = '0;
               push_cnt_d = '0;
               overflow_d = 1'b0;
               held_vld_d = 1'b0;
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
               wrap_d     = wrap_en;
            end
         end
         S_CAPTURE, S_DRAIN: begin
            if (pop) begin
               rd_ptr_d = rd_ptr_q + PTR_ONE;
               addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + ONE_W;
               words_d  = words_q + ONE_W;
            end
            if (state_q == S_CAPTURE) begin
               if (sample_valid) begin
                  if (held_vld_q) begin
                     held_vld_d = 1'b0;
                     push_cnt_d = push_cnt_q + ONE_W;
                     if (push) wr_ptr_d   = wr_ptr_q + PTR_ONE;
                     else      overflow_d = 1'b1;
                  end else begin
                     held_d     = sample;
                     held_vld_d = 1'b1;
                  end
               end
               // A lone low byte has no partner any more and is discarded.
               if (stop || quota_hit) begin
                  state_d    = S_DRAIN;
                  held_vld_d = 1'b0;
               end
            end else if (fifo_count == (pop ? PTR_ONE : '0)) begin
               // FIFO is empty after this edge: done the cycle after the last write.
               state_d = S_DONE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge M100CLK or posedge reset) begin
      if (reset) begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples pre-edge values regardless of block evaluation order.
         state_q    <= S_IDLE;
         addr_q     <= '0;
         words_q    <= '0;
         push_cnt_q <= '0;
         overflow_q <= 1'b0;
         wrap_q     <= 1'b0;
         held_q     <= '0;
         held_vld_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         words_q    <= words_d;
         push_cnt_q <= push_cnt_d;
         overflow_q <= overflow_d;
         wrap_q     <= wrap_d;
         held_q     <= held_d;
         held_vld_q <= held_vld_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // NOTE: the storage array has no reset; the pointers define which entries
   // are valid, and resettable RAM would prevent block-RAM mapping.
   always_ff @(posedge M100CLK) begin
      if (push) fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= {sample, held_q};
   end

   // Data is forced to zero when no write is requested so idle outputs are clean.
   assign av.Avalon_Address    = addr_q;
   assign av.Avalon_WriteData  = av_write ? fifo_mem[rd_ptr_q[FIFO_AW-1:0]] : 16'h0000;
   assign av.Avalon_ByteEnable = 2'b11;
   assign av.Avalon_ChipEnable = active;
   assign av.Avalon_Write      = av_write;

   assign busy          = active;
   assign done          = (state_q == S_DONE);
   assign overflow      = overflow_q;
   assign words_written = words_q;

endmodule

// File: doc/sdram_capture_writer.md
# sdram_capture_writer

Upstream capture stage of the DRFM sample path. It packs pairs of 8-bit ADC samples into 16-bit words and buffers them in a 16-word FIFO. It then writes those words as linear, word-addressed Avalon-MM bursts of single writes into SDRAM, where the playback controller later reads them back. Its Avalon master port is the write-side master selected by the controller's master multiplexer.

## Interface
- `ADDR_W`, 25: Avalon word-address width.
- `LAST_ADDR`, 25'h1FF_FFFF: last word address of the capture region.
- `FIFO_AW`, 4: FIFO address width; depth is 2^FIFO_AW = 16 words.

Ports:
- `M100CLK`  in  1  system clock (100 MHz); the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `arm`  in  1  single-cycle start pulse; honoured only in IDLE or DONE.
- `stop`  in  1  single-cycle stop pulse; honoured only in CAPTURE.
- `wrap_en`  in  1  1 = circular capture, 0 = one-shot; sampled on `arm`.
- `sample`  in  8  ADC sample.
- `sample_valid`  in  1  `sample` is valid this cycle.
- `Avalon_Address`  out  ADDR_W  word address.
- `Avalon_WriteData`  out  16  write data.
- `Avalon_ByteEnable`  out  2  constant 2'b11 (active-high).
- `Avalon_ChipEnable`  out  1  1 while `busy`.
- `Avalon_Write`  out  1  active-high write request.
- `Avalon_WaitRequest`  in  1  slave stall.
- `busy`  out  1  state is CAPTURE or DRAIN.
- `done`  out  1  state is DONE.
- `overflow`  out  1  sticky; a packed word was dropped because the FIFO was full.
- `words_written`  out  ADDR_W  count of accepted Avalon writes since the last `arm`; wraps modulo 2^ADDR_W.

## Operation
- States are IDLE, CAPTURE, DRAIN and DONE.
- IDLE→CAPTURE on `arm`. The same transition applies from DONE. On this transition:
  - address := 0, `words_written` := 0, `overflow` := 0;
  - the pack register and the FIFO are cleared;
  - `wrap_en` is latched.
- Packing, in CAPTURE only:
  - The first valid sample is held in the low byte.
  - The second valid sample forms the word {sample, held}, so the earlier sample lands in [7:0].
  - The word is pushed into the FIFO on that same edge.
- Word quota, one-shot mode:
  - After LAST_ADDR+1 words have been pushed, sample acceptance stops and the state goes CAPTURE→DRAIN.
  - Dropped words count toward the quota.
- `stop` in CAPTURE→DRAIN. Any lone held low byte is discarded.
- If the quota is reached and `stop` arrives on the same cycle, the quota word is still pushed.
- In wrap mode, CAPTURE continues indefinitely until `stop`. The address wraps from LAST_ADDR to 0.
- FIFO-full push:
  - The word is dropped and `overflow` is set.
  - The address does not advance; no gap is left in memory.
  - If the FIFO pops on the same edge, the push succeeds. Full is evaluated after the pop.
- Avalon write rules:
  - `Avalon_Write` = FIFO not empty AND state ∈ {CAPTURE, DRAIN}.
  - `Avalon_WriteData` = FIFO head; `Avalon_Address` = current address.
  - A transfer completes on any edge where `Avalon_Write`=1 and `Avalon_WaitRequest`=0. On that edge the FIFO pops, the address increments (wrapping as above) and `words_written` increments.
  - While `Avalon_WaitRequest`=1, address and data are held stable.
- DRAIN→DONE when the FIFO is empty.
- DONE holds until the next `arm`.
- `arm` during CAPTURE or DRAIN is ignored. `stop` outside CAPTURE is ignored.

## Timing
- Reset values:
  - state IDLE;
  - all outputs 0, except `Avalon_ByteEnable`=2'b11;
  - FIFO empty, pack register empty.
- Reset has immediate effect at any point. Reset mid-write drops `Avalon_Write` asynchronously, and the incomplete write is abandoned.
- `arm` at edge N: `busy`=1 and `Avalon_ChipEnable`=1 from cycle N+1. The first sample is accepted at edge N+1 at the earliest.
- Second sample of a pair at edge K: `Avalon_Write`=1 during cycle K+1 (one-cycle latency), provided the FIFO was empty.
- Sustained throughput is one write per cycle with `WaitRequest`=0. Capture at one sample per cycle therefore never overflows under that condition.
- The final accepted write at edge M, with the FIFO empty and the state in DRAIN: `done`=1 and `busy`=0 from cycle M+1.
- FIFO provides show-ahead: the head is valid in the same cycle as not-empty.

## Test plan
- One-shot, `LAST_ADDR`=7, 16 samples 0x00..0x0F at one per cycle, `WaitRequest`=0 → writes at addresses 0..7 with data 0x0100, 0x0302, …, 0x0F0E; `done` rises; `words_written`=8; `overflow`=0.
- Same run with `WaitRequest` held high for 5 cycles on the third write → address 2 and data 0x0504 are held for 5 cycles; write order and data are unchanged.
- `WaitRequest`=1 for 40 cycles with continuous samples → `overflow`=1 after the 16th buffered word; remaining words are written to consecutive addresses with no gaps; the next `arm` clears `overflow`.
- Wrap mode, `LAST_ADDR`=3, 12 pairs → address sequence 0,1,2,3,0,1,…; `stop` after an odd sample → the lone byte is discarded, the FIFO drains, then `done`.
- Async `reset` asserted mid-capture with a non-empty FIFO, a held byte and `WaitRequest`=1 → all outputs return to reset values immediately; a subsequent `arm` restarts at address 0.
- `arm` pulsed during DRAIN and `stop` pulsed in IDLE → both ignored; state and counters are unchanged.
